// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Two-port round-robin arbiter and wait-state sequencer for the
//             shared instruction/data memory (port 0 = CPU, port 1 = DMA).
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int LAT = 1,
    parameter int AW  = 12,
    parameter int DW  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          busy,
    output logic [AW-1:0] memAddress,
    output logic [DW-1:0] memWriteData,
    output logic          MemRead,
    output logic          MemWrite,
    input  logic [DW-1:0] memReadData
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Access counter preload; ACCESS lasts LAT cycles ending when it hits 0.
    localparam logic [3:0] C_CNT_INIT = 4'(LAT - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic            r_last;
    logic            r_cur;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata0;
    logic [DW-1:0]   r_rdata1;
    logic            w_grant;
    logic            w_start;
    logic            w_last_beat;

    // Round-robin pick: a lone requester wins, a tie goes to the port that
    // was not granted last time.
    always_comb begin
        w_grant = 1'b0;
        if (req0 && req1) begin
            w_grant = ~r_last;
        end else if (req1) begin
            w_grant = 1'b1;
        end
    end

    assign w_start     = (r_state == S_IDLE) && (req0 || req1);
    assign w_last_beat = (r_state == S_ACCESS) && (r_cnt == 4'd0);

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and outputs decoded purely from registered state, so
    // no request input ever reaches the memory bus combinationally.
    always_comb begin
        w_state_nxt  = r_state;
        busy         = 1'b0;
        ack0         = 1'b0;
        ack1         = 1'b0;
        memAddress   = '0;
        memWriteData = '0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                busy         = 1'b1;
                memAddress   = r_addr;
                memWriteData = r_we ? r_wdata : '0;
                MemRead      = ~r_we;
                MemWrite     = r_we;
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                ack0        = ~r_cur;
                ack1        = r_cur;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Request capture, wait-state counter and round-robin history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= 4'd0;
            r_last  <= 1'b1;
            r_cur   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_start) begin
            r_cnt   <= C_CNT_INIT;
            r_last  <= w_grant;
            r_cur   <= w_grant;
            r_we    <= w_grant ? we1    : we0;
            r_addr  <= w_grant ? addr1  : addr0;
            r_wdata <= w_grant ? wdata1 : wdata0;
        end else if ((r_state == S_ACCESS) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Read-data return registers; only a completing read of that port updates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (w_last_beat && !r_we) begin
            if (r_cur) begin
                r_rdata1 <= memReadData;
            end else begin
                r_rdata0 <= memReadData;
            end
        end
    end

    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the single shared 12-bit-address / 16-bit-data instruction/data memory. It lets the multicycle CPU (port 0) and a second master, such as a DMA/program loader (port 1), take turns on the one memory port. The block sits between the two masters and the memory. It owns the `memAddress` / `memWriteData` / `MemRead` / `MemWrite` / `memReadData` bus and inserts wait states according to a fixed memory latency.

## Interface
- `LAT`, default 1: memory access cycles per transaction; legal range 1–15.
- `AW`, default 12: address width.
- `DW`, default 16: data width.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `req0` / `req1`  in  1  request from port 0 (CPU) / port 1.
- `we0` / `we1`  in  1  1 = write, 0 = read.
- `addr0` / `addr1`  in  AW  access address.
- `wdata0` / `wdata1`  in  DW  write data.
- `ack0` / `ack1`  out  1  one-cycle completion pulse.
- `rdata0` / `rdata1`  out  DW  last read data returned to that port.
- `busy`  out  1  high in every state except IDLE.
- `memAddress`  out  AW  memory address.
- `memWriteData`  out  DW  memory write data.
- `MemRead` / `MemWrite`  out  1  memory strobes.
- `memReadData`  in  DW  memory read data; valid by the end of the LAT-th access cycle.

## Operation
- Requester rules:
  - Hold `req`, `we`, `addr` and `wdata` stable until `ack` is seen.
  - Drop `req`, or present a new request, in the cycle after `ack`.
- FSM has three states:
  - IDLE → ACCESS when `req0` or `req1` is high. At that edge: latch the winner's `we`/`addr`/`wdata` and the winner index `cur`; load counter = LAT-1.
  - ACCESS: drive the latched request onto the memory bus. Decrement the counter each cycle. Go to DONE at the edge where counter = 0.
    - If the transaction is a read, capture `memReadData` into `rdata[cur]` at that same edge.
  - DONE: hold `ack[cur]` high for exactly this cycle. Always return to IDLE; no request is accepted in DONE.
- Arbitration is round-robin with a 1-bit `last` register:
  - Only one requester high: it wins.
  - Both requesters high: the port ≠ `last` wins.
  - `last` ← `cur` on entry to ACCESS.
  - `last` resets to 1, so port 0 wins the first tie.
- Memory bus:
  - In ACCESS: `memAddress`=latched addr, `memWriteData`=latched wdata (0 on reads), `MemRead`=!we, `MemWrite`=we.
  - In IDLE and DONE: all memory outputs are 0.
  - `MemRead` and `MemWrite` are never high together.
  - All memory outputs and acks are registered or decoded from registered state only; there is no combinational path from `req*` to memory outputs.
- `rdata0`/`rdata1` change only on a completed read for that port. Writes and the other port's reads leave them unchanged.
- A requester dropping `req` mid-transaction does not abort it. The access completes and `ack` still pulses.

## Timing
- Request high in IDLE during cycle 0:
  - ACCESS occupies cycles 1..LAT.
  - `ack` is high in cycle LAT+1.
  - IDLE again in cycle LAT+2.
- Latency: LAT+1 cycles from request to `ack`.
- Throughput: one transaction per LAT+2 cycles.
- With both ports continuously requesting, grants strictly alternate. Neither port waits more than one transaction.
- Reset (`rst`=0, at any time including mid-ACCESS or DONE) takes effect immediately:
  - state=IDLE, counter=0, `last`=1, `cur`=0.
  - `ack0`=`ack1`=0, `busy`=0.
  - `rdata0`=`rdata1`=0, all memory outputs 0.
  - The in-flight transaction is abandoned with no `ack` pulse.
- First request can be accepted at the first rising edge after `rst` deasserts.
- Counter width: 4 bits, matching the LAT range 1–15.

## Test plan
- Reset values: assert `rst`=0 mid-ACCESS of a write → all outputs 0 at once, no `ack`. After release, `busy`=0 until a request is made.
- Single read, LAT=1, port 0, `addr0`=0x123, memory returns 0xBEEF → `MemRead`=1 with `memAddress`=0x123 in cycle 1 only. `ack0`=1 in cycle 2 with `rdata0`=0xBEEF. `rdata1` unchanged.
- Single write, LAT=3, port 1, `addr1`=0xFFF, `wdata1`=0x5A5A → `MemWrite`=1 for exactly cycles 1–3 with that address and data. `ack1` in cycle 4. `rdata0`/`rdata1` unchanged.
- Simultaneous `req0`=`req1`=1 held continuously for 4 transactions, LAT=1 → grant order 0,1,0,1. Acks in cycles 2, 5, 8, 11. `MemRead`/`MemWrite` never both 1.
- `req1` high alone, then `req0` rises while port 1 is in ACCESS → port 1 completes undisturbed. Port 0 is granted on the next IDLE, and the memory bus shows port 0's address only after port 1's DONE cycle.
- `req0` dropped during ACCESS of a read → `ack0` still pulses at cycle LAT+1 and `rdata0` is updated. FSM returns to IDLE.
